// File: rtl/seq_matcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_matcher_pkg
// Purpose  : Shared types and width helpers for the serial pattern matcher.
//            - sm_state_t   : matcher FSM state encoding
//            - fill_width() : bits needed to count 0..PAT_W valid beats
//            - wdog_width() : bits needed to count 0..TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
package seq_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        ERROR = 2'd2
    } sm_state_t;

    // Fill counter must reach PAT_W itself, hence PAT_W+1 values.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // A disabled watchdog (TIMEOUT=0) still gets a 1-bit vector so that
    // port widths stay legal.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : sm_watchdog
// Purpose  : Free-running cycle counter with synchronous clear and enable.
//            tc is high while the count sits at TIMEOUT-1, i.e. on the last
//            cycle before a timeout. TIMEOUT=0 ties tc low.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-low reset
//            clr  - synchronous clear (priority over en)
//            en   - count enable
//            tc   - terminal count
// Revision : 1.0 - initial release
// ============================================================================
module sm_watchdog #(
    parameter int TIMEOUT = 128,
    parameter int WD_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr, en};
            assign tc       = 1'b0;
        end else begin : g_counter
            localparam logic [WD_W-1:0] c_LAST = WD_W'(TIMEOUT - 1);
            logic [WD_W-1:0] r_count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_count <= '0;
                end else if (clr) begin
                    r_count <= '0;
                end else if (en) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign tc = (r_count == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_matcher.sv
`default_nettype none
// ============================================================================
// Module   : seq_matcher
// Purpose  : Serial bit-pattern detector with programmable pattern/mask,
//            overlapping or non-overlapping matches, saturating match
//            counter and a no-match watchdog with sticky error.
// Ports    : clk, rst (async active-low)
//            enable    - arms the matcher, low returns to IDLE
//            din       - serial data bit, sampled when din_valid=1
//            pattern   - target pattern, bit 0 = newest bit
//            mask      - 1 = compare bit, 0 = don't care
//            overlap   - 1 = overlapping matches allowed
//            clr       - clears error and match_cnt
//            found     - one-cycle pulse per match
//            match_cnt - saturating match count
//            error     - sticky watchdog timeout
//            busy      - high while hunting
// Revision : 1.0 - initial release
// ============================================================================
module seq_matcher
    import seq_matcher_pkg::*;
#(
    parameter int PAT_W   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
    input  logic             clr,
    output logic             found,
    output logic [CNT_W-1:0] match_cnt,
    output logic             error,
    output logic             busy
);

    localparam int c_FILL_W = fill_width(PAT_W);
    localparam int c_WD_W   = wdog_width(TIMEOUT);
    localparam logic [c_FILL_W-1:0] c_FULL = c_FILL_W'(PAT_W);

    sm_state_t            r_state;
    sm_state_t            w_state_next;
    // The oldest bit is compared on the beat that shifts it out, so only
    // PAT_W-1 history bits need storing.
    logic [PAT_W-2:0]     r_sr;
    logic [c_FILL_W-1:0]  r_fill;
    logic [PAT_W-1:0]     r_pat;
    logic [PAT_W-1:0]     r_mask;

    logic [PAT_W-1:0]     w_sr_next;
    logic [c_FILL_W-1:0]  w_fill_next;
    logic                 w_shift;
    logic                 w_match;
    logic                 w_tc;
    logic                 w_timeout;
    logic                 w_arm;
    logic                 w_wd_clr;

    assign w_shift     = (r_state == HUNT) && enable && din_valid;
    assign w_sr_next   = {r_sr, din};
    assign w_fill_next = (r_fill == c_FULL) ? c_FULL : r_fill + 1'b1;
    assign w_match     = w_shift && (w_fill_next == c_FULL) &&
                         (((w_sr_next ^ r_pat) & r_mask) == '0);
    // A match on the terminal-count cycle wins over the timeout.
    assign w_timeout   = (r_state == HUNT) && enable && w_tc && !w_match;
    assign w_wd_clr    = (r_state != HUNT) || w_match;
    assign busy        = (r_state == HUNT);

    sm_watchdog #(
        .TIMEOUT (TIMEOUT),
        .WD_W    (c_WD_W)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (w_wd_clr),
        .en  (r_state == HUNT),
        .tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = HUNT;
                    w_arm        = 1'b1;
                end
            end
            HUNT: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_state_next = ERROR;
                end
            end
            ERROR: begin
                // Only clr leaves ERROR; enable merely picks the target.
                if (clr) begin
                    if (enable) begin
                        w_state_next = HUNT;
                        w_arm        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr      <= '0;
            r_fill    <= '0;
            r_pat     <= '0;
            r_mask    <= '0;
            found     <= 1'b0;
            match_cnt <= '0;
            error     <= 1'b0;
        end else begin
            found <= w_match;

            if (w_arm) begin
                r_pat  <= pattern;
                r_mask <= mask;
            end

            // Every fresh hunt and every drop of enable starts from an
            // empty history; ERROR keeps the history frozen.
            if (w_arm || (r_state == IDLE) || ((r_state == HUNT) && !enable)) begin
                r_sr   <= '0;
                r_fill <= '0;
            end else if (w_shift) begin
                r_sr   <= w_sr_next[PAT_W-2:0];
                r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
            end

            if (clr) begin
                match_cnt <= '0;
            end else if (w_match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end

            if (w_timeout) begin
                error <= 1'b1;
            end else if (clr) begin
                error <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_matcher
// Purpose  : Self-checking bench for seq_matcher (PAT_W=8, CNT_W=16,
//            TIMEOUT=128). Stimulus pushes expected found events into a
//            queue; a monitor pops and compares whenever found is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_matcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        din;
    logic        din_valid;
    logic [7:0]  pattern;
    logic [7:0]  mask;
    logic        overlap;
    logic        clr;
    logic        found;
    logic [15:0] match_cnt;
    logic        error;
    logic        busy;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   armc;
    int   c0;
    logic [7:0] bytes [3];

    seq_matcher #(
        .PAT_W   (8),
        .CNT_W   (16),
        .TIMEOUT (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .din       (din),
        .din_valid (din_valid),
        .pattern   (pattern),
        .mask      (mask),
        .overlap   (overlap),
        .clr       (clr),
        .found     (found),
        .match_cnt (match_cnt),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every found pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && found === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_found: found=1 at cycle %0d cnt=%0d, none expected",
                         cyc, match_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.cyc || int'(match_cnt) != e.cnt) begin
                    n_bad++;
                    $display("FAIL found_event: got cycle %0d cnt %0d, expected cycle %0d cnt %0d",
                             cyc, match_cnt, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic b, input logic v, input logic hit, input int cnt);
        exp_t e;
        @(negedge clk);
        din       = b;
        din_valid = v;
        if (hit) begin
            e.cyc = cyc + 1;
            e.cnt = cnt;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic arm(input logic [7:0] p, input logic [7:0] m, input logic ov);
        @(negedge clk);
        pattern   = p;
        mask      = m;
        overlap   = ov;
        enable    = 1'b1;
        din_valid = 1'b0;
    endtask

    task automatic disarm();
        @(negedge clk);
        enable    = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr       = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        clr       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        pattern   = 8'h00;
        mask      = 8'h00;
        overlap   = 1'b0;
        clr       = 1'b0;
        bytes[0]  = 8'h35;
        bytes[1]  = 8'hF5;
        bytes[2]  = 8'h36;

        // Reset state
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_found", found, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // 1: overlapping 0xAA on 1010101010 -> matches after beats 8 and 10
        arm(8'hAA, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++)
            beat((i % 2) == 0, 1'b1, (i == 7) || (i == 9), (i == 9) ? 2 : 1);
        idle(2);
        chk("t1_busy", busy, 1);
        chk("t1_cnt", match_cnt, 2);
        chk("t1_drain", q.size(), 0);
        disarm();

        // 2: same stream, non-overlapping -> single match after beat 8
        pulse_clr();
        chk("t2_cnt_clr", match_cnt, 0);
        arm(8'hAA, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++)
            beat((i % 2) == 0, 1'b1, i == 7, 1);
        idle(2);
        chk("t2_cnt", match_cnt, 1);
        chk("t2_drain", q.size(), 0);
        disarm();

        // 3: masked low nibble 0x5; bytes 35, F5, 36 MSB first -> beats 8, 16
        pulse_clr();
        arm(8'h05, 8'h0F, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 7; j >= 0; j--) begin
                int idx;
                idx = k * 8 + (7 - j);
                beat(bytes[k][j], 1'b1, (idx == 7) || (idx == 15), (idx == 15) ? 2 : 1);
            end
        end
        idle(2);
        chk("t3_cnt", match_cnt, 2);
        chk("t3_drain", q.size(), 0);
        disarm();

        // 4: watchdog fires 128 cycles after arm; count is retained
        arm(8'hAA, 8'hFF, 1'b1);
        @(negedge clk);
        armc = cyc;
        chk("t4_busy_arm", busy, 1);
        while (!error && cyc < armc + 200) @(negedge clk);
        chk("t4_err_cycle", cyc - armc, 128);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        for (int i = 0; i < 8; i++)
            beat((i % 2) == 0, 1'b1, 1'b0, 0);
        idle(2);
        chk("t4_cnt_frozen", match_cnt, 2);
        pulse_clr();
        c0 = cyc;
        chk("t4_clr_error", error, 0);
        chk("t4_clr_cnt", match_cnt, 0);
        chk("t4_clr_busy", busy, 1);

        // 5: completing beat sampled while wdog==127 -> match wins
        while (cyc < c0 + 119) @(negedge clk);
        for (int i = 0; i < 8; i++)
            beat((i % 2) == 0, 1'b1, i == 7, 1);
        @(negedge clk);
        din_valid = 1'b0;
        chk("t5_err_at_match", error, 0);
        chk("t5_busy", busy, 1);
        while (!error && cyc < c0 + 400) @(negedge clk);
        chk("t5_err_cycle", cyc - c0, 256);
        chk("t5_drain", q.size(), 0);
        disarm();
        idle(3);
        chk("t5_sticky", error, 1);
        pulse_clr();
        chk("t5_clr_error", error, 0);
        chk("t5_clr_idle", busy, 0);
        chk("t5_clr_cnt", match_cnt, 0);

        // 6: gapped valid beats, then async reset between clock edges
        arm(8'hAA, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            beat((i % 2) == 0, 1'b1, i == 7, 1);
            beat((i % 2) != 0, 1'b0, 1'b0, 0);
        end
        for (int i = 0; i < 3; i++)
            beat((i % 2) == 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        din_valid = 1'b0;
        chk("t6_cnt", match_cnt, 1);
        chk("t6_drain", q.size(), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_found", found, 0);
        chk("t6_rst_cnt", match_cnt, 0);
        chk("t6_rst_error", error, 0);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_matcher.md
Name: seq_matcher

Overview:
- Parametrised serial bit-pattern detector with a programmable pattern and mask, and overlapping or non-overlapping match modes.
- Counts matches and runs a watchdog: if no match arrives within TIMEOUT cycles, it raises a sticky error.
- Sits on a 1-bit serial receive path and qualifies each bit with a valid strobe; it is the generalised successor of the fixed 3-bit matcher.

Parameters:
- PAT_W, 8: pattern length in bits (minimum 2).
- CNT_W, 16: width of the match counter.
- TIMEOUT, 128: cycles without a match before error is raised; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  arms the matcher; low returns it to IDLE.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when high.
- pattern  input  PAT_W  target pattern; bit 0 is the newest bit.
- mask  input  PAT_W  1 = compare this bit, 0 = don't care.
- overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- clr  input  1  clears error and match_cnt; single-cycle.
- found  output  1  one-cycle pulse per match.
- match_cnt  output  CNT_W  saturating count of matches.
- error  output  1  sticky watchdog timeout flag.
- busy  output  1  high in HUNT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; sr, fill, wdog, found, match_cnt, error and the latched pattern/mask all 0; busy=0.
- FSM states: IDLE, HUNT, ERROR.
  - IDLE: sr, fill and wdog held at 0. enable=1 -> HUNT; pattern and mask are latched on this transition and used unchanged for the rest of the hunt.
  - HUNT: enable=0 -> IDLE. Timeout -> ERROR.
  - ERROR: matching is frozen and found stays 0. clr -> HUNT if enable=1 (pattern/mask re-latched), else IDLE. ERROR is left only on clr or reset; enable=0 alone does not exit it.
- Shift register (HUNT only, on din_valid=1): sr <= {sr[PAT_W-2:0], din}; fill increments, saturating at PAT_W. Cycles with din_valid=0 change neither sr nor fill.
- Match condition, evaluated on the cycle the shift is registered: valid beat AND fill==PAT_W after the shift AND ((sr_next ^ pat_l) & mask_l)==0.
- Match response:
  - found=1 on the clock edge after the completing beat (1-cycle latency), for exactly one cycle.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - wdog resets to 0.
- overlap=0: on a match, fill resets to 0, so the next match needs PAT_W fresh valid beats. overlap=1: fill stays saturated.
- mask all zero: every valid beat matches once fill==PAT_W.
- Watchdog:
  - wdog resets to 0 on entry to HUNT, increments every clk cycle in HUNT, and resets on each match.
  - When wdog==TIMEOUT-1 and there is no match that cycle: error <= 1, state <= ERROR. error therefore rises TIMEOUT cycles after the arm edge.
  - TIMEOUT=0: wdog never fires.
- Simultaneous events:
  - Match and timeout in the same cycle: match wins; no error, wdog -> 0.
  - clr and match in the same cycle: found still pulses; match_cnt -> 0 (clr has priority).
  - clr in HUNT: clears match_cnt only; hunt state is unaffected.
- enable dropping mid-pattern: partial pattern is discarded (sr and fill cleared); match_cnt is retained.
- busy = (state==HUNT).

Decomposition:
- Package seq_matcher_pkg:
  - state enum (IDLE, HUNT, ERROR);
  - localparam for the fill counter width, $clog2(PAT_W+1);
  - watchdog width, $clog2(TIMEOUT+1).
- Sub-module sm_watchdog: cycle counter with clear, enable and terminal-count output; TIMEOUT=0 ties terminal count low.
- Shift register, compare logic and FSM stay in seq_matcher.

Test Plan:
- PAT_W=8, pattern=8'hAA, mask=8'hFF, overlap=1; stream 1010101010 on consecutive valid beats -> found pulses after beats 8 and 10; match_cnt=2.
- Same stream with overlap=0 -> single found after beat 8; match_cnt=1.
- mask=8'h0F, pattern=8'h05; bytes 8'h35 then 8'hF5, MSB first -> found after beats 8 and 16; bytes 8'h36 -> no found.
- TIMEOUT=128, enable with no matches:
  - error rises exactly 128 cycles after arm, busy drops, further matching stream gives no found;
  - clr with enable=1 -> error=0, match_cnt=0, busy=1.
- Completing beat timed so the match lands on wdog==127 -> found=1, error stays 0, wdog restarts.
- din_valid toggling 1/0 with pattern bits only on valid beats -> match after the 8th valid beat; assert rst low mid-stream between clock edges -> all outputs 0 immediately.
